// File: rtl/sb_xbar_dbuf.sv
// sb_xbar_dbuf: switch box with one output mux per track per side and double-buffered serial config
module sb_xbar_dbuf #(
  parameter int WIDTH = 32,
  localparam int CFG_PER_TRACK = 16,
  localparam int CFG_BITS = WIDTH * CFG_PER_TRACK
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [WIDTH-1:0] north_in,
  input  logic [WIDTH-1:0] east_in,
  input  logic [WIDTH-1:0] south_in,
  input  logic [WIDTH-1:0] west_in,
  output logic [WIDTH-1:0] north_out,
  output logic [WIDTH-1:0] east_out,
  output logic [WIDTH-1:0] south_out,
  output logic [WIDTH-1:0] west_out,
  input  logic             config_en,
  input  logic             config_data_in,
  output logic             config_data_out,
  input  logic             config_commit,
  output logic             config_full,
  output logic             config_err
);
  localparam int CW = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CFG_BITS);
  logic [CFG_BITS-1:0] r_shadow, r_active;
  logic [CW-1:0] r_cnt;
  logic r_err;
  logic [3:0][WIDTH-1:0] w_in, w_mux, w_out, r_q;
  logic w_full, w_shift;
  assign w_in = {west_in, south_in, east_in, north_in};
  assign w_full = r_cnt == FULL;
  assign w_shift = config_en & ~config_commit;
  // Shadow chain shifts regardless of en; a commit in the same cycle suppresses the shift
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      r_shadow <= '0;
      r_cnt <= '0;
    end else begin
      if (w_shift) r_shadow <= {r_shadow[CFG_BITS-2:0], config_data_in};
      if (config_commit && w_full) r_cnt <= '0;
      else if (w_shift && !w_full) r_cnt <= r_cnt + CW'(1);
    end
  // Accepted commit swaps routing atomically; a rejected one raises a one-cycle error
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      r_active <= '0;
      r_err <= 1'b0;
    end else begin
      if (config_commit && w_full) r_active <= r_shadow;
      r_err <= config_commit & ~w_full;
    end
  // Output flops track their mux only while the fabric is enabled
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) r_q <= '0;
    else if (en) r_q <= w_mux;
  for (genvar t = 0; t < WIDTH; t++) begin : g_trk
    for (genvar d = 0; d < 4; d++) begin : g_dir
      logic [3:0] w_c;
      logic [1:0] w_src;
      assign w_c = r_active[t*CFG_PER_TRACK + d*4 +: 4];
      assign w_src = w_c[1:0] - 2'd1;
      assign w_mux[d][t] = (w_c[2:0] >= 3'd1 && w_c[2:0] <= 3'd4 && w_src != 2'(d)) ? w_in[w_src][t] : 1'b0;
      assign w_out[d][t] = w_c[3] ? r_q[d][t] : w_mux[d][t];
    end
  end
  assign north_out = w_out[0];
  assign east_out = w_out[1];
  assign south_out = w_out[2];
  assign west_out = w_out[3];
  assign config_data_out = r_shadow[CFG_BITS-1];
  assign config_full = w_full;
  assign config_err = r_err;
endmodule

// File: tb/tb_sb_xbar_dbuf.sv
// tb_sb_xbar_dbuf: vector table, corner sequences and random traffic against a reference model
module tb_sb_xbar_dbuf;
  localparam int W = 32;
  localparam int NB = W * 16;
  logic clk = 0, nrst = 0, en = 0;
  logic config_en = 0, config_data_in = 0, config_commit = 0;
  logic [W-1:0] north_in = '0, east_in = '0, south_in = '0, west_in = '0;
  logic [W-1:0] north_out, east_out, south_out, west_out;
  logic config_data_out, config_full, config_err;

  sb_xbar_dbuf #(.WIDTH(W)) dut (
    .clk(clk), .nrst(nrst), .en(en),
    .north_in(north_in), .east_in(east_in), .south_in(south_in), .west_in(west_in),
    .north_out(north_out), .east_out(east_out), .south_out(south_out), .west_out(west_out),
    .config_en(config_en), .config_data_in(config_data_in), .config_data_out(config_data_out),
    .config_commit(config_commit), .config_full(config_full), .config_err(config_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic [1:0] n, e, s, w;
    logic [1:0] xn, xe, xs, xw;
  } vec_t;
  vec_t tv[8];

  logic [NB-1:0] m_act;
  bit sq[$];
  int mcnt;
  logic merr;
  logic [W-1:0] mq[4];
  int n_cmp = 0, n_bad = 0;

  function automatic logic in_bit(int s, int t);
    case (s)
      0: return north_in[t];
      1: return east_in[t];
      2: return south_in[t];
      default: return west_in[t];
    endcase
  endfunction

  function automatic logic [W-1:0] mux_vec(int d);
    logic [W-1:0] v = '0;
    for (int t = 0; t < W; t++) begin
      int sel = int'(m_act[t*16 + d*4 +: 3]);
      if (sel >= 1 && sel <= 4 && sel - 1 != d) v[t] = in_bit(sel - 1, t);
    end
    return v;
  endfunction

  function automatic logic [W-1:0] exp_out(int d);
    logic [W-1:0] m = mux_vec(d);
    logic [W-1:0] v;
    for (int t = 0; t < W; t++) v[t] = m_act[t*16 + d*4 + 3] ? mq[d][t] : m[t];
    return v;
  endfunction

  function automatic logic [W-1:0] act_out(int d);
    case (d)
      0: return north_out;
      1: return east_out;
      2: return south_out;
      default: return west_out;
    endcase
  endfunction

  function automatic logic [NB-1:0] shadow_vec();
    logic [NB-1:0] v = '0;
    for (int i = 0; i < sq.size(); i++) v[i] = sq[i];
    return v;
  endfunction

  function automatic logic exp_cdo();
    return (sq.size() == NB) ? sq[NB-1] : 1'b0;
  endfunction

  task automatic cmp(string nm, logic [W-1:0] got, logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic check(string tag);
    #1;
    for (int d = 0; d < 4; d++) cmp($sformatf("%s_out%0d", tag, d), act_out(d), exp_out(d));
    cmp({tag, "_cdo"}, config_data_out, exp_cdo());
    cmp({tag, "_full"}, config_full, mcnt == NB);
    cmp({tag, "_err"}, config_err, merr);
  endtask

  task automatic tick();
    logic [W-1:0] nq[4];
    @(posedge clk);
    for (int d = 0; d < 4; d++) nq[d] = en ? mux_vec(d) : mq[d];
    if (config_commit) begin
      if (mcnt == NB) begin
        m_act = shadow_vec();
        mcnt = 0;
        merr = 0;
      end else merr = 1;
    end else begin
      merr = 0;
      if (config_en) begin
        sq.push_front(config_data_in);
        if (sq.size() > NB) void'(sq.pop_back());
        if (mcnt < NB) mcnt++;
      end
    end
    #1;
    for (int d = 0; d < 4; d++) mq[d] = nq[d];
  endtask

  task automatic rand_in();
    north_in = $urandom;
    east_in = $urandom;
    south_in = $urandom;
    west_in = $urandom;
  endtask

  task automatic do_reset();
    nrst = 0;
    config_en = 0;
    config_commit = 0;
    rand_in();
    m_act = '0;
    sq.delete();
    mcnt = 0;
    merr = 0;
    for (int d = 0; d < 4; d++) mq[d] = '0;
    check("rst");
    @(negedge clk);
    nrst = 1;
    check("rst_rel");
  endtask

  task automatic shift(logic b);
    config_en = 1;
    config_data_in = b;
    tick();
    config_en = 0;
    check("sh");
  endtask

  task automatic commit(logic cen);
    config_commit = 1;
    config_en = cen;
    config_data_in = 1'($urandom);
    tick();
    config_commit = 0;
    config_en = 0;
    check("cm");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [NB-1:0] cfg;
    logic first;
    tv[0] = '{1'b1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    tv[1] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
    tv[2] = '{1'b0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10};
    tv[3] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tv[4] = '{1'b1, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    tv[5] = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    tv[6] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    tv[7] = '{1'b0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10};
    cfg = '0;
    cfg[15:0] = 16'h00C3;
    cfg[31:16] = 16'h2711;

    do_reset();
    for (int i = 0; i < 3; i++) begin
      rand_in();
      tick();
      check("post_rst");
    end

    do_reset();
    north_in = '0; east_in = '0; south_in = '0; west_in = '0;
    for (int i = NB - 1; i >= 1; i--) shift(cfg[i]);
    commit(0);
    cmp("early_err", config_err, 1);
    cmp("early_full", config_full, 0);
    tick();
    check("early_after");
    cmp("early_err_drop", config_err, 0);
    shift(cfg[0]);
    cmp("full_at_512", config_full, 1);
    commit(1);
    cmp("full_cleared", config_full, 0);
    cmp("commit_no_err", config_err, 0);

    for (int i = 0; i < 8; i++) begin
      en = tv[i].en;
      north_in = {30'($urandom), tv[i].n};
      east_in = {30'($urandom), tv[i].e};
      south_in = {30'($urandom), tv[i].s};
      west_in = {30'($urandom), tv[i].w};
      check("tbl");
      cmp($sformatf("tbl%0d_n", i), north_out, {30'b0, tv[i].xn});
      cmp($sformatf("tbl%0d_e", i), east_out, {30'b0, tv[i].xe});
      cmp($sformatf("tbl%0d_s", i), south_out, {30'b0, tv[i].xs});
      cmp($sformatf("tbl%0d_w", i), west_out, {30'b0, tv[i].xw});
      tick();
    end

    en = 1;
    first = 1'($urandom);
    for (int i = 0; i < 600; i++) begin
      config_en = 1;
      config_data_in = (i == 0) ? first : 1'($urandom);
      tick();
      config_en = 0;
      rand_in();
      south_in[0] = i[0];
      check("db");
      cmp("db_route", north_out[0], i[0]);
      if (i == NB - 1) cmp("daisy_first_bit", config_data_out, first);
    end

    do_reset();
    for (int i = 0; i < 200; i++) shift(1'($urandom));
    do_reset();
    commit(0);
    cmp("rst_mid_err", config_err, 1);
    cmp("rst_mid_full", config_full, 0);

    do_reset();
    for (int i = 0; i < NB; i++) shift(1'($urandom));
    commit(0);
    for (int i = 0; i < 1200; i++) begin
      rand_in();
      en = 1'($urandom);
      config_en = ($urandom % 4) != 0;
      config_data_in = 1'($urandom);
      config_commit = ($urandom % 60) == 0;
      tick();
      config_commit = 0;
      config_en = 0;
      rand_in();
      check("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
